// File: rtl/serial_rx_package.sv
// serial_rx_package: 8N1 UART receiver assembling 2**AddressWidth words (highest first) into one packet.
// Define SERIAL_RX_PACKAGE_TIMEOUT_EN to discard partial packets after TimeoutBits idle bit periods.
module serial_rx_package #(
    parameter int AddressWidth     = 2,
    parameter int WordWidth        = 8,
    parameter int SerialTimerWidth = 8,
    parameter int TimeoutBits      = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rx,
    output logic [2**AddressWidth*WordWidth-1:0]  data,
    output logic                                  valid,
    output logic                                  busy,
    output logic                                  error
);
    localparam int DataWidth = 2**AddressWidth*WordWidth;
    localparam int BitCountWidth = $clog2(WordWidth + 1);
    localparam logic [SerialTimerWidth-1:0] HalfPeriod = SerialTimerWidth'(2**(SerialTimerWidth-1) - 1);
    localparam logic [SerialTimerWidth-1:0] FullPeriod = '1;

    if (SerialTimerWidth < 2 || TimeoutBits < 1) begin : gBadParams
        $error("serial_rx_package: SerialTimerWidth must be >= 2 and TimeoutBits >= 1");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateType;

    stateType                    state;
    logic                        rxMeta, rxs, rxsPrev;
    logic [SerialTimerWidth-1:0] timer;
    logic [BitCountWidth-1:0]    bitCount;
    logic [WordWidth-1:0]        shiftReg;
    logic [AddressWidth-1:0]     wordCount;
    logic [AddressWidth-1:0]     slot;
    logic [DataWidth-1:0]        assembly, nextAssembly;
    logic                        startEdge, tick;

`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
    localparam int IdleWidth = $clog2(TimeoutBits) + SerialTimerWidth + 1;
    localparam logic [IdleWidth-1:0] IdleLimit = IdleWidth'(TimeoutBits * 2**SerialTimerWidth - 1);
    logic [IdleWidth-1:0] idleCount;
`endif

    assign startEdge = rxsPrev & ~rxs;
    assign tick = timer == '0;
    assign busy = (state != IDLE) || (wordCount != '0);
    // Slot Words-1-wordCount is simply the bitwise inverse of wordCount.
    assign slot = ~wordCount;

    always_comb begin
        nextAssembly = assembly;
        nextAssembly[int'(slot)*WordWidth +: WordWidth] = shiftReg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rxMeta    <= 1'b1;
            rxs       <= 1'b1;
            rxsPrev   <= 1'b1;
            timer     <= '0;
            bitCount  <= '0;
            shiftReg  <= '0;
            wordCount <= '0;
            assembly  <= '0;
            data      <= '0;
            valid     <= 1'b0;
            error     <= 1'b0;
`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
            idleCount <= '0;
`endif
        end else begin
            rxMeta  <= rx;
            rxs     <= rxMeta;
            rxsPrev <= rxs;
            valid   <= 1'b0;
            error   <= 1'b0;
            timer   <= timer - 1'b1;
            case (state)
                IDLE: if (startEdge) begin
                    state <= START;
                    timer <= HalfPeriod;
                end
                START: if (tick) begin
                    state    <= rxs ? IDLE : DATA;
                    timer    <= FullPeriod;
                    bitCount <= '0;
                end
                DATA: if (tick) begin
                    shiftReg <= {rxs, shiftReg[WordWidth-1:1]};
                    timer    <= FullPeriod;
                    bitCount <= bitCount + 1'b1;
                    if (bitCount == BitCountWidth'(WordWidth - 1)) state <= STOP;
                end
                STOP: if (tick) begin
                    state <= IDLE;
                    if (rxs) begin
                        assembly  <= nextAssembly;
                        wordCount <= wordCount + 1'b1;
                        if (&wordCount) begin
                            data  <= nextAssembly;
                            valid <= 1'b1;
                        end
                    end else begin
                        error     <= 1'b1;
                        wordCount <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
            // A start edge leaves IDLE, so it always beats a coincident timeout.
            if (state != IDLE || wordCount == '0 || startEdge) begin
                idleCount <= '0;
            end else if (idleCount == IdleLimit) begin
                idleCount <= '0;
                wordCount <= '0;
                error     <= 1'b1;
            end else begin
                idleCount <= idleCount + 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_serial_rx_package.sv
// tb_serial_rx_package: directed frames with hand-computed packets for serial_rx_package (P=16).
module tb_serial_rx_package;
    localparam int P = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic [31:0] data;
    logic        valid, busy, error;

    int tests = 0;
    int failed = 0;
    int validCount = 0;
    int errorCount = 0;
    logic [31:0] dataQ[$];
    logic prevValid = 1'b0;
    logic prevError = 1'b0;

    serial_rx_package #(
        .AddressWidth(2), .WordWidth(8), .SerialTimerWidth(4), .TimeoutBits(16)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            validCount++;
            dataQ.push_back(data);
            check("validOneCycle", 32'(prevValid), 32'd0);
        end
        if (error) begin
            errorCount++;
            check("errorOneCycle", 32'(prevError), 32'd0);
        end
        prevValid = valid;
        prevError = error;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBits(input logic [9:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            repeat (P) @(negedge clk);
        end
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stopBit);
        sendBits({stopBit, d, 1'b0}, 10);
    endtask

    task automatic sendPacket(input logic [31:0] p);
        for (int i = 3; i >= 0; i--) sendFrame(p[i*8 +: 8], 1'b1);
    endtask

    task automatic checkCleared(input string tag);
        check({tag, "Data"}, data, 32'd0);
        check({tag, "Valid"}, 32'(valid), 32'd0);
        check({tag, "Busy"}, 32'(busy), 32'd0);
        check({tag, "Error"}, 32'(error), 32'd0);
    endtask

    int v0, e0;

    initial begin
        repeat (3) @(negedge clk);
        checkCleared("reset");
        rst = 1'b0;
        idle(4);

        v0 = validCount; e0 = errorCount;
        sendPacket(32'h12345678);
        idle(4);
        check("nomValid", 32'(validCount - v0), 32'd1);
        check("nomData", data, 32'h12345678);
        check("nomBusy", 32'(busy), 32'd0);
        check("nomError", 32'(errorCount - e0), 32'd0);

        v0 = validCount; e0 = errorCount;
        rx = 1'b0;
        repeat (6) @(negedge clk);
        idle(3 * P);
        check("glitchValid", 32'(validCount - v0), 32'd0);
        check("glitchError", 32'(errorCount - e0), 32'd0);
        check("glitchBusy", 32'(busy), 32'd0);
        check("glitchData", data, 32'h12345678);

        v0 = validCount; e0 = errorCount;
        sendFrame(8'h12, 1'b1);
        sendFrame(8'h34, 1'b0);
        idle(2 * P);
        check("frameError", 32'(errorCount - e0), 32'd1);
        check("frameNoValid", 32'(validCount - v0), 32'd0);
        check("frameBusy", 32'(busy), 32'd0);
        sendPacket(32'hA1B2C3D4);
        idle(4);
        check("frameNextValid", 32'(validCount - v0), 32'd1);
        check("frameNextData", data, 32'hA1B2C3D4);

        sendFrame(8'h99, 1'b1);
        sendBits({1'b1, 8'h55, 1'b0}, 4);
        repeat (P / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkCleared("midReset");
        rst = 1'b0;
        idle(2 * P);
        check("postResetBusy", 32'(busy), 32'd0);
        v0 = validCount;
        sendPacket(32'hDEADBEEF);
        idle(4);
        check("postResetValid", 32'(validCount - v0), 32'd1);
        check("postResetData", data, 32'hDEADBEEF);

        v0 = validCount;
        sendPacket(32'h01020304);
        sendPacket(32'h05060708);
        idle(4);
        check("b2bValid", 32'(validCount - v0), 32'd2);
        check("b2bFirst", dataQ[dataQ.size() - 2], 32'h01020304);
        check("b2bSecond", dataQ[dataQ.size() - 1], 32'h05060708);
        check("b2bBusy", 32'(busy), 32'd0);

        v0 = validCount; e0 = errorCount;
        sendFrame(8'hAA, 1'b1);
        sendFrame(8'hBB, 1'b1);
        idle(16 * P + 2);
`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
        check("timeoutError", 32'(errorCount - e0), 32'd1);
        check("timeoutBusy", 32'(busy), 32'd0);
`else
        check("noTimeoutError", 32'(errorCount - e0), 32'd0);
        check("noTimeoutBusy", 32'(busy), 32'd1);
`endif
        sendPacket(32'h11223344);
        idle(4);
        check("timeoutValid", 32'(validCount - v0), 32'd1);
`ifdef SERIAL_RX_PACKAGE_TIMEOUT_EN
        check("timeoutData", data, 32'h11223344);
        check("timeoutEndBusy", 32'(busy), 32'd0);
`else
        check("noTimeoutData", data, 32'hAABB1122);
        check("noTimeoutEndBusy", 32'(busy), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
